ex_stage: RTL

- Execute stage with integrated EX/MEM pipeline register.
- Consumes the ID/EX register outputs (EX_*), computes the 64-bit ALU result, and registers the result plus control into the EX/MEM register (MEM_* outputs).
- Single-cycle ops pass straight through. MUL is iterative and multi-cycle, and holds the upstream pipeline via ex_stall.

---
 rtl/ex_stage.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//   Execute stage with the EX/MEM pipeline register folded in. Takes the
//   ID/EX register outputs (EX_*), computes the 64-bit ALU result and
//   registers result and control into the MEM_* outputs.
//
//   Single-cycle ops reach MEM_* one edge after they appear on EX_*.
//   MUL is an iterative shift-and-add multiplier that consumes MUL_BITS
//   multiplier bits per cycle (N = 64/MUL_BITS iterations). While it runs,
//   ex_stall holds the upstream pipeline and MEM_* carries bubbles.
//
// Handshake: ex_stall is combinational. While ex_stall = 1 the upstream
//   stages (PC, IF/ID, ID/EX) must keep their contents, so EX_* is stable.
//   The cycle with ex_stall = 0 is the one in which the instruction on EX_*
//   is consumed, and the next edge may advance upstream.
//
// Ports:
//   clk           pipeline clock, rising edge
//   reset         asynchronous, active-high reset
//   EX_WRegEn     register-write enable from ID/EX
//   EX_WMemEn     memory-write enable from ID/EX
//   EX_R1out      operand A
//   EX_R2out      operand B / store data
//   EX_WReg1      destination register
//   EX_ALUopcode  ALU operation
//   MEM_WRegEn    registered register-write enable
//   MEM_WMemEn    registered memory-write enable
//   MEM_ALUout    registered ALU result / memory address
//   MEM_R2out     registered store data
//   MEM_WReg1     registered destination register
//   ex_stall      upstream hold request (combinational)
//   fsm_state     debug view of the multiplier FSM (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module ex_stage #(
    // Must divide 64.
    parameter int MUL_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_WRegEn,
    input  logic        EX_WMemEn,
    input  logic [63:0] EX_R1out,
    input  logic [63:0] EX_R2out,
    input  logic [4:0]  EX_WReg1,
    input  logic [3:0]  EX_ALUopcode,
    output logic        MEM_WRegEn,
    output logic        MEM_WMemEn,
    output logic [63:0] MEM_ALUout,
    output logic [63:0] MEM_R2out,
    output logic [4:0]  MEM_WReg1,
    output logic        ex_stall,
    output logic [1:0]  fsm_state
);

    localparam int N     = 64 / MUL_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Multiplier datapath registers.
    logic [63:0]      mcand_q;
    logic [63:0]      mplier_q;
    logic [63:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Control strobes from the FSM to the datapath.
    logic start_mul;
    logic step_mul;
    logic stall_raw;

    // Next values for the EX/MEM register.
    logic        mem_wregen_d;
    logic        mem_wmemen_d;
    logic [63:0] mem_aluout_d;
    logic [63:0] mem_r2out_d;
    logic [4:0]  mem_wreg1_d;

    logic        active;
    logic        is_mul_op;
    logic [5:0]  shamt;
    logic [63:0] alu_result;
    logic [63:0] mul_digit;
    logic [63:0] partial;

    assign active    = EX_WRegEn | EX_WMemEn;
    assign is_mul_op = (EX_ALUopcode == OP_MUL);
    assign shamt     = EX_R2out[5:0];

    // ------------------------------------------------------------------
    // Single-cycle ALU. MUL yields 0 here; its result comes from acc_q.
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = 64'd0;
        case (EX_ALUopcode)
            OP_ADD:   alu_result = EX_R1out + EX_R2out;
            OP_SUB:   alu_result = EX_R1out - EX_R2out;
            OP_AND:   alu_result = EX_R1out & EX_R2out;
            OP_OR:    alu_result = EX_R1out | EX_R2out;
            OP_XOR:   alu_result = EX_R1out ^ EX_R2out;
            OP_SLL:   alu_result = EX_R1out << shamt;
            OP_SRL:   alu_result = EX_R1out >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(EX_R1out) >>> shamt);
            OP_SLT:   alu_result = {63'd0, ($signed(EX_R1out) < $signed(EX_R2out))};
            OP_SLTU:  alu_result = {63'd0, (EX_R1out < EX_R2out)};
            OP_PASSB: alu_result = EX_R2out;
            default:  alu_result = 64'd0;
        endcase
    end

    // One radix-2^MUL_BITS digit of the multiplier times the (pre-shifted)
    // multiplicand. Only the low 64 bits of the product are ever needed, so
    // the multiplicand is allowed to shift its upper bits out.
    assign mul_digit = 64'(mplier_q[MUL_BITS-1:0]);
    assign partial   = mcand_q * mul_digit;

    // ------------------------------------------------------------------
    // FSM: next state, stall and EX/MEM next values.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        stall_raw    = 1'b0;
        start_mul    = 1'b0;
        step_mul     = 1'b0;
        mem_wregen_d = 1'b0;
        mem_wmemen_d = 1'b0;
        mem_aluout_d = 64'd0;
        mem_r2out_d  = 64'd0;
        mem_wreg1_d  = 5'd0;

        case (state_q)
            IDLE: begin
                if (is_mul_op && active) begin
                    // Stall in the same cycle the MUL shows up so ID/EX holds it.
                    stall_raw = 1'b1;
                    start_mul = 1'b1;
                    state_d   = MUL_RUN;
                end else if (!is_mul_op) begin
                    mem_wregen_d = EX_WRegEn;
                    mem_wmemen_d = EX_WMemEn;
                    mem_aluout_d = alu_result;
                    mem_r2out_d  = EX_R2out;
                    mem_wreg1_d  = EX_WReg1;
                end
                // An inactive MUL leaves the all-zero bubble defaults.
            end

            MUL_RUN: begin
                stall_raw = 1'b1;
                step_mul  = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = MUL_DONE;
                end
            end

            MUL_DONE: begin
                // Operands came from the latched copies; control is taken
                // from ID/EX now, which upstream has held throughout.
                mem_wregen_d = EX_WRegEn;
                mem_wmemen_d = EX_WMemEn;
                mem_aluout_d = acc_q;
                mem_r2out_d  = EX_R2out;
                mem_wreg1_d  = EX_WReg1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset forces IDLE asynchronously, but IDLE with a MUL on EX_* would
    // otherwise still raise the stall, so it is masked while reset is high.
    assign ex_stall  = stall_raw & ~reset;
    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier datapath.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= 64'd0;
            mplier_q <= 64'd0;
            acc_q    <= 64'd0;
            cnt_q    <= '0;
        end else if (start_mul) begin
            mcand_q  <= EX_R1out;
            mplier_q <= EX_R2out;
            acc_q    <= 64'd0;
            cnt_q    <= '0;
        end else if (step_mul) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_WRegEn <= 1'b0;
            MEM_WMemEn <= 1'b0;
            MEM_ALUout <= 64'd0;
            MEM_R2out  <= 64'd0;
            MEM_WReg1  <= 5'd0;
        end else begin
            MEM_WRegEn <= mem_wregen_d;
            MEM_WMemEn <= mem_wmemen_d;
            MEM_ALUout <= mem_aluout_d;
            MEM_R2out  <= mem_r2out_d;
            MEM_WReg1  <= mem_wreg1_d;
        end
    end

endmodule
